fpadd_align_seq: RTL and testbench

- Multi-cycle exponent-alignment sequencer for the 32-bit FP adder.
- Accepts two IEEE-754 single operands over a valid/ready handshake.
- Uses one comp8 instance to compare the biased exponents and obtain their difference.
- Right-shifts the smaller significand over successive cycles, with guard/round/sticky (GRS) tracking, and presents the aligned pair to the add/normalise stage.

---
 rtl/fpadd_pkg.sv | 35 +++
 rtl/comp8.sv | 27 ++
 rtl/fpadd_sticky_shr.sv | 39 +++
 rtl/fpadd_align_seq.sv | 189 ++++++++++++++++++
 tb/tb_fpadd_align_seq.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpadd_pkg.sv
// -----------------------------------------------------------------------------
// fpadd_pkg
// Shared definitions for the FP adder front end:
//   - widths of the exponent, the extended significand and the GRS tail
//   - the saturating shift distance of the alignment stage
//   - FSM state encoding of the alignment sequencer
//   - helpers that unpack an IEEE-754 single exponent/fraction
// -----------------------------------------------------------------------------
package fpadd_pkg;

    localparam int EXP_W     = 8;
    localparam int GRS_W     = 3;
    localparam int MAN_W     = 27;   // hidden + 23 fraction bits + GRS
    localparam int SAT_SHIFT = 27;   // any larger shift leaves only sticky
    localparam int CNT_W     = 5;    // remaining shift never exceeds 26 in SHIFT

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Denormals share the exponent of the smallest normal (1).
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    // {hidden, fraction, GRS=000}; the hidden bit is set for any nonzero exponent.
    function automatic logic [MAN_W-1:0] unpack_sig(input logic [EXP_W-1:0] e,
                                                   input logic [22:0]      f);
        return {|e, f, {GRS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/comp8.sv
// -----------------------------------------------------------------------------
// comp8
// 8-bit unsigned magnitude comparator with absolute difference.
// Ports:
//   a, b      in  8  values to compare
//   a_lt_b    out 1  a < b
//   abs_diff  out 8  |a - b|
// Parameter T is the per-gate delay of the gate-level model; this
// implementation is purely functional and only range-checks it.
// -----------------------------------------------------------------------------
module comp8 #(
    parameter real T = 0.000
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       a_lt_b,
    output logic [7:0] abs_diff
);

    if (T < 0.0) begin : g_bad_t
        $error("comp8: T must be non-negative");
    end

    assign a_lt_b   = (a < b);
    assign abs_diff = a_lt_b ? (b - a) : (a - b);

endmodule

// File: rtl/fpadd_sticky_shr.sv
// -----------------------------------------------------------------------------
// fpadd_sticky_shr
// Logical right shift of the 27-bit significand by 0..SHIFT_STEP bits.
// Every bit that falls off the bottom is ORed into bit 0 (sticky).
// Ports:
//   din    in  27  significand before this step
//   shamt  in  3   shift amount, 0..SHIFT_STEP
//   dout   out 27  shifted significand with sticky folded into bit 0
// -----------------------------------------------------------------------------
module fpadd_sticky_shr
    import fpadd_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic [MAN_W-1:0] din,
    input  logic [2:0]       shamt,
    output logic [MAN_W-1:0] dout
);

    // One candidate per legal shift amount; the mux below picks one.
    logic [MAN_W-1:0] cand [0:SHIFT_STEP];

    for (genvar gi = 0; gi <= SHIFT_STEP; gi++) begin : g_cand
        logic lost;
        // Bits [gi-1:0] are about to be shifted out; gi=0 loses nothing.
        assign lost      = |(din & ((MAN_W'(1) << gi) - MAN_W'(1)));
        assign cand[gi]  = (din >> gi) | {{(MAN_W-1){1'b0}}, lost};
    end

    always_comb begin
        dout = cand[0];
        for (int i = 1; i <= SHIFT_STEP; i++) begin
            if (shamt == 3'(i)) begin
                dout = cand[i];
            end
        end
    end

endmodule

// File: rtl/fpadd_align_seq.sv
// -----------------------------------------------------------------------------
// fpadd_align_seq
// Multi-cycle exponent-alignment sequencer of the single-precision adder.
// Takes an operand pair over valid/ready, compares the effective exponents
// with comp8, then shifts the smaller significand right SHIFT_STEP bits per
// cycle (sticky-tracked) until it lines up with the larger one.
// Ports:
//   clk, rst     clock / asynchronous active-high reset
//   in_valid     operand pair valid          in_ready   can accept operands
//   a, b         IEEE-754 single operands
//   out_valid    aligned pair valid          out_ready  downstream accepts
//   exp_big      effective exponent of the larger-exponent operand
//   sign_big     sign of the larger-exponent operand
//   sign_small   sign of the smaller-exponent operand
//   man_big      {hidden, frac, 000} of the larger operand
//   man_small    aligned smaller significand, bit 0 sticky
//   swap         1 when B is the larger-exponent operand
// -----------------------------------------------------------------------------
module fpadd_align_seq
    import fpadd_pkg::*;
#(
    parameter real T          = 0.000,
    parameter int  SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_big,
    output logic             sign_big,
    output logic             sign_small,
    output logic [MAN_W-1:0] man_big,
    output logic [MAN_W-1:0] man_small,
    output logic             swap
);

    if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4)) begin : g_bad_step
        $error("fpadd_align_seq: SHIFT_STEP must be 1, 2 or 4");
    end

    localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(SHIFT_STEP);
    localparam logic [2:0]       STEP_SH  = 3'(SHIFT_STEP);

    state_t state_reg, state_next;

    logic [31:0]      a_reg, b_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [EXP_W-1:0] exp_big_reg;
    logic             sign_big_reg, sign_small_reg, swap_reg;
    logic [MAN_W-1:0] man_big_reg, man_small_reg;

    // ---------------- exponent compare (registered operands only) ----------
    logic [EXP_W-1:0] ea_eff, eb_eff, abs_diff;
    logic             a_lt_b;

    assign ea_eff = eff_exp(a_reg[30:23]);
    assign eb_eff = eff_exp(b_reg[30:23]);

    comp8 #(.T(T)) u_comp8 (
        .a        (ea_eff),
        .b        (eb_eff),
        .a_lt_b   (a_lt_b),
        .abs_diff (abs_diff)
    );

    logic [31:0]      big_word, small_word;
    logic [MAN_W-1:0] sig_big, sig_small;
    logic             diff_zero, diff_sat;

    // Ties keep A as the big operand.
    assign big_word   = a_lt_b ? b_reg : a_reg;
    assign small_word = a_lt_b ? a_reg : b_reg;
    assign sig_big    = unpack_sig(big_word[30:23],   big_word[22:0]);
    assign sig_small  = unpack_sig(small_word[30:23], small_word[22:0]);
    assign diff_zero  = (abs_diff == '0);
    assign diff_sat   = (abs_diff >= EXP_W'(SAT_SHIFT));

    // ---------------- per-cycle shift ---------------------------------------
    logic [2:0]       shamt;
    logic [CNT_W-1:0] cnt_after;
    logic [MAN_W-1:0] shr_out;

    assign shamt     = (cnt_reg > STEP_CNT) ? STEP_SH : cnt_reg[2:0];
    assign cnt_after = cnt_reg - {{(CNT_W-3){1'b0}}, shamt};

    fpadd_sticky_shr #(.SHIFT_STEP(SHIFT_STEP)) u_shr (
        .din   (man_small_reg),
        .shamt (shamt),
        .dout  (shr_out)
    );

    // ---------------- FSM ---------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                // Equal exponents need no shift; huge gaps collapse to sticky.
                if (diff_zero || diff_sat) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_after == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers -----------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg          <= '0;
            b_reg          <= '0;
            cnt_reg        <= '0;
            exp_big_reg    <= '0;
            sign_big_reg   <= 1'b0;
            sign_small_reg <= 1'b0;
            swap_reg       <= 1'b0;
            man_big_reg    <= '0;
            man_small_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                    end
                end
                ST_COMPARE: begin
                    swap_reg       <= a_lt_b;
                    exp_big_reg    <= a_lt_b ? eb_eff : ea_eff;
                    sign_big_reg   <= big_word[31];
                    sign_small_reg <= small_word[31];
                    man_big_reg    <= sig_big;
                    if (diff_sat) begin
                        man_small_reg <= {{(MAN_W-1){1'b0}}, |sig_small};
                        cnt_reg       <= '0;
                    end else begin
                        man_small_reg <= sig_small;
                        cnt_reg       <= abs_diff[CNT_W-1:0];
                    end
                end
                ST_SHIFT: begin
                    man_small_reg <= shr_out;
                    cnt_reg       <= cnt_after;
                end
                default: ;
            endcase
        end
    end

    assign exp_big    = exp_big_reg;
    assign sign_big   = sign_big_reg;
    assign sign_small = sign_small_reg;
    assign man_big    = man_big_reg;
    assign man_small  = man_small_reg;
    assign swap       = swap_reg;

endmodule

// File: tb/tb_fpadd_align_seq.sv
// -----------------------------------------------------------------------------
// tb_fpadd_align_seq
// Three sequencers (SHIFT_STEP = 1, 2, 4) share one stimulus stream. Each
// transaction is checked against an arithmetic reference model; a vector
// table adds hand-computed expectations, and hand-written sequences cover
// back-pressure, in_valid while busy and asynchronous reset mid-shift.
// -----------------------------------------------------------------------------
module tb_fpadd_align_seq;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        in_ready_w   [NI];
    logic        out_valid_w  [NI];
    logic        sign_big_w   [NI];
    logic        sign_small_w [NI];
    logic        swap_w       [NI];
    logic [7:0]  exp_big_w    [NI];
    logic [26:0] man_big_w    [NI];
    logic [26:0] man_small_w  [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        fpadd_align_seq #(.T(0.0), .SHIFT_STEP(1 << gi)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready_w[gi]),
            .a          (a),
            .b          (b),
            .out_valid  (out_valid_w[gi]),
            .out_ready  (out_ready),
            .exp_big    (exp_big_w[gi]),
            .sign_big   (sign_big_w[gi]),
            .sign_small (sign_small_w[gi]),
            .man_big    (man_big_w[gi]),
            .man_small  (man_small_w[gi]),
            .swap       (swap_w[gi])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int lat_got [NI];

    typedef struct {
        logic        swap;
        logic        sign_big;
        logic        sign_small;
        logic [7:0]  exp_big;
        logic [26:0] man_big;
        logic [26:0] man_small;
        int          lat;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        swap;
        logic [7:0]  exp_big;
        logic [26:0] man_big;
        logic [26:0] man_small;
        int          lat1;
        int          lat4;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    // Reference: exact alignment as integer arithmetic. The smaller
    // significand is divided by 2^d; any nonzero remainder sets bit 0.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input int step);
        res_t   r;
        int     ex, ey, d;
        longint sx, sy, sb, ss, al;
        ex = int'(x[30:23]); if (ex == 0) ex = 1;
        ey = int'(y[30:23]); if (ey == 0) ey = 1;
        sx = ((x[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(x[22:0]);
        sy = ((y[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(y[22:0]);
        sx = sx * 8;
        sy = sy * 8;
        r.swap       = (ey > ex);
        d            = r.swap ? ey - ex : ex - ey;
        sb           = r.swap ? sy : sx;
        ss           = r.swap ? sx : sy;
        r.sign_big   = r.swap ? y[31] : x[31];
        r.sign_small = r.swap ? x[31] : y[31];
        r.exp_big    = 8'(r.swap ? ey : ex);
        if (d >= 27) begin
            al = (ss != 0) ? 1 : 0;
        end else begin
            al = ss / (longint'(1) << d);
            if ((ss % (longint'(1) << d)) != 0) al = al | 1;
        end
        r.man_big   = sb[26:0];
        r.man_small = al[26:0];
        r.lat       = (d == 0 || d >= 27) ? 2 : 2 + (d + step - 1) / step;
        return r;
    endfunction

    // Present an operand pair; returns at the negedge after the accept edge.
    task automatic accept_op(input logic [31:0] ia, input logic [31:0] ib);
        @(negedge clk);
        a = ia;
        b = ib;
        in_valid = 1'b1;
        for (int i = 0; i < NI; i++) chk($sformatf("in_ready_idle[%0d]", i), 64'(in_ready_w[i]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for every instance to present a result; check vs model.
    task automatic collect(input logic [31:0] ia, input logic [31:0] ib);
        bit   seen [NI];
        int   n;
        res_t r;
        for (int i = 0; i < NI; i++) begin seen[i] = 1'b0; lat_got[i] = 0; end
        n = 0;
        while (!(seen[0] && seen[1] && seen[2]) && n < 80) begin
            @(posedge clk);
            n++;
            #1;
            for (int i = 0; i < NI; i++) begin
                if (!seen[i] && out_valid_w[i]) begin
                    seen[i]    = 1'b1;
                    lat_got[i] = n + 1;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            r = model(ia, ib, 1 << i);
            if (!seen[i]) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout[%0d] got=no out_valid expected=out_valid by cycle %0d", i, r.lat);
            end else begin
                chk($sformatf("latency[%0d]", i),    64'(lat_got[i]),      64'(r.lat));
                chk($sformatf("swap[%0d]", i),       64'(swap_w[i]),       64'(r.swap));
                chk($sformatf("sign_big[%0d]", i),   64'(sign_big_w[i]),   64'(r.sign_big));
                chk($sformatf("sign_small[%0d]", i), 64'(sign_small_w[i]), 64'(r.sign_small));
                chk($sformatf("exp_big[%0d]", i),    64'(exp_big_w[i]),    64'(r.exp_big));
                chk($sformatf("man_big[%0d]", i),    64'(man_big_w[i]),    64'(r.man_big));
                chk($sformatf("man_small[%0d]", i),  64'(man_small_w[i]),  64'(r.man_small));
            end
        end
        $display("[TB] txn a=%08h b=%08h swap=%0d exp_big=%02h man_big=%07h man_small=%07h lat=%0d/%0d/%0d",
                 ia, ib, swap_w[0], exp_big_w[0], man_big_w[0], man_small_w[0],
                 lat_got[0], lat_got[1], lat_got[2]);
    endtask

    // Pulse out_ready for one cycle; every instance must return to IDLE.
    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("in_ready_after_pop[%0d]", i),  64'(in_ready_w[i]),  64'd1);
            chk($sformatf("out_valid_after_pop[%0d]", i), 64'(out_valid_w[i]), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_in_ready[%0d]", tag, i),  64'(in_ready_w[i]),  64'd1);
            chk($sformatf("%s_out_valid[%0d]", tag, i), 64'(out_valid_w[i]), 64'd0);
            chk($sformatf("%s_data[%0d]", tag, i),
                64'({swap_w[i], sign_big_w[i], sign_small_w[i], exp_big_w[i]}), 64'd0);
            chk($sformatf("%s_man_big[%0d]", tag, i),   64'(man_big_w[i]),   64'd0);
            chk($sformatf("%s_man_small[%0d]", tag, i), 64'(man_small_w[i]), 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=simulation still running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tab [8];
        logic [37:0] snap_hi [NI];
        logic [26:0] snap_ms [NI];
        logic [31:0] ra, rb;
        int          mode, e;

        tab[0] = '{32'h40400000, 32'h3F800000, 1'b0, 8'h80, 27'h6000000, 27'h2000000,  3, 3};
        tab[1] = '{32'h3F800000, 32'h40400000, 1'b1, 8'h80, 27'h6000000, 27'h2000000,  3, 3};
        tab[2] = '{32'h3F800000, 32'h3F800000, 1'b0, 8'h7F, 27'h4000000, 27'h4000000,  2, 2};
        tab[3] = '{32'h64000000, 32'h3F800001, 1'b0, 8'hC8, 27'h4000000, 27'h0000001,  2, 2};
        tab[4] = '{32'h4B800000, 32'h3F800001, 1'b0, 8'h97, 27'h4000000, 27'h0000005, 26, 8};
        tab[5] = '{32'h00000001, 32'h00800000, 1'b0, 8'h01, 27'h0000008, 27'h4000000,  2, 2};
        tab[6] = '{32'h4C800000, 32'h3F800001, 1'b0, 8'h99, 27'h4000000, 27'h0000001, 28, 9};
        tab[7] = '{32'h3F800000, 32'h4D000000, 1'b1, 8'h9A, 27'h4000000, 27'h0000001,  2, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int v = 0; v < 8; v++) begin
            accept_op(tab[v].a, tab[v].b);
            collect(tab[v].a, tab[v].b);
            chk($sformatf("tab%0d_swap", v),      64'(swap_w[0]),      64'(tab[v].swap));
            chk($sformatf("tab%0d_exp_big", v),   64'(exp_big_w[0]),   64'(tab[v].exp_big));
            chk($sformatf("tab%0d_man_big", v),   64'(man_big_w[0]),   64'(tab[v].man_big));
            chk($sformatf("tab%0d_man_small", v), 64'(man_small_w[0]), 64'(tab[v].man_small));
            chk($sformatf("tab%0d_man_small4", v), 64'(man_small_w[2]), 64'(tab[v].man_small));
            chk($sformatf("tab%0d_lat1", v),      64'(lat_got[0]),     64'(tab[v].lat1));
            chk($sformatf("tab%0d_lat4", v),      64'(lat_got[2]),     64'(tab[v].lat4));
            release_out();
        end

        // Back-pressure: hold the result 5 cycles while a new pair waits
        accept_op(32'hC1200000, 32'h3E000003);
        collect(32'hC1200000, 32'h3E000003);
        for (int i = 0; i < NI; i++) begin
            snap_hi[i] = {swap_w[i], sign_big_w[i], sign_small_w[i], exp_big_w[i], man_big_w[i]};
            snap_ms[i] = man_small_w[i];
        end
        @(negedge clk);
        a = 32'h42F60000;
        b = 32'hC2C80001;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("hold%0d_fields[%0d]", c, i),
                    64'({swap_w[i], sign_big_w[i], sign_small_w[i], exp_big_w[i], man_big_w[i]}),
                    64'(snap_hi[i]));
                chk($sformatf("hold%0d_man_small[%0d]", c, i), 64'(man_small_w[i]), 64'(snap_ms[i]));
                chk($sformatf("hold%0d_in_ready[%0d]", c, i),  64'(in_ready_w[i]),  64'd0);
                chk($sformatf("hold%0d_out_valid[%0d]", c, i), 64'(out_valid_w[i]), 64'd1);
            end
        end
        release_out();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        collect(32'h42F60000, 32'hC2C80001);
        release_out();

        // Asynchronous reset in the middle of a d=20 shift
        accept_op(32'h49800000, 32'hBF812345);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("midshift_out_valid[%0d]", i), 64'(out_valid_w[i]), 64'd0);
            chk($sformatf("midshift_man_big[%0d]", i),   64'(man_big_w[i]),   64'h4000000);
        end
        #1;
        rst = 1'b1;
        #1;
        chk_cleared("async_rst");
        @(negedge clk);
        rst = 1'b0;
        accept_op(32'h49800000, 32'hBF812345);
        collect(32'h49800000, 32'hBF812345);
        release_out();

        // Randomised pairs, biased toward interesting exponent gaps
        for (int t = 0; t < 30; t++) begin
            ra   = $urandom;
            mode = $urandom_range(0, 3);
            rb   = $urandom;
            case (mode)
                1: begin
                    e = int'(ra[30:23]) + ($urandom_range(0, 1) ? 1 : -1) * int'($urandom_range(0, 30));
                    if (e < 0) e = 0;
                    if (e > 255) e = 255;
                    rb[30:23] = 8'(e);
                end
                2: rb[30:23] = 8'd0;
                3: rb[30:23] = ra[30:23];
                default: ;
            endcase
            accept_op(ra, rb);
            collect(ra, rb);
            release_out();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
